dmem_lsu: RTL and testbench

Load/store unit that acts as the initiator side of the byte-enabled synchronous data memory port. It accepts core load/store requests through a valid/ready handshake and converts each into dmem port cycles: per-byte write enables, word address, lane-rotated write data. It extracts and sign- or zero-extends load data after the memory's 1-cycle read latency. It sits between the execute stage and dmem.

---
 rtl/dmem_lsu.sv | 198 +++++++++++++++++++
 tb/tb_dmem_lsu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit: core request handshake to a byte-enabled dmem port with load extraction.
// Define DMEM_LSU_MISALIGN_EN to support word-crossing accesses as two dmem cycles.
module dmem_lsu #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic [3:0]        dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_din,
    input  logic [XLEN-1:0]   dmem_dout
);

    typedef enum logic [1:0] {StIdle, StLdWait, StLdSplit, StStSplit} state_e;

    state_e            state_q, state_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   din_q, din_d;
    logic [XLEN-1:0]   hold_q, hold_d;
    logic              cross_q, cross_d;
    logic              rsp_valid_d, rsp_err_d;
    logic [XLEN-1:0]   rsp_rdata_d;

    logic [1:0]        off;
    logic [ADDR_W-1:0] word;
    logic [3:0]        mask, we_lo, we;
    logic [XLEN-1:0]   rot;
    logic              legal, crossing, err;

    always_comb begin
        off  = req_addr[1:0];
        word = req_addr[ADDR_W+1:2];
        case (req_funct3[1:0])
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        we_lo = mask << off;
        // Rotate left by 8*off; both halves of a split store use the same lanes.
        rot   = XLEN'(({req_wdata, req_wdata} << {off, 3'b000}) >> XLEN);
        legal = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                       : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end

`ifdef DMEM_LSU_MISALIGN_EN
    logic [2:0] size;
    logic [3:0] we_hi, we_hi_q;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        crossing = ({1'b0, off} + size) > 3'd4;
        we_hi    = mask >> (3'd4 - {1'b0, off});
        err      = !legal;
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            we_hi_q <= '0;
        end else if (req_valid && req_ready) begin
            we_hi_q <= we_hi;
        end
    end
`else
    logic aligned;

    always_comb begin
        aligned  = (req_funct3[1:0] == 2'b00) || (off == 2'b00) ||
                   ((req_funct3[1:0] == 2'b01) && !off[0]);
        crossing = 1'b0;
        err      = !legal || !aligned;
    end
`endif

    // Load extraction: split loads combine {upper word, lower word held from the first read}.
    logic [2*XLEN-1:0] ld_src;
    logic [XLEN-1:0]   ld_word, ld_ext;

    always_comb begin
        ld_src  = cross_q ? {dmem_dout, hold_q} : {{XLEN{1'b0}}, dmem_dout};
        ld_word = XLEN'(ld_src >> {off_q, 3'b000});
        case (f3_q)
            3'b000:  ld_ext = {{(XLEN-8){ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_word[7:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        word_d      = word_q;
        f3_d        = f3_q;
        din_d       = din_q;
        cross_d     = cross_q;
        hold_d      = hold_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        req_ready   = 1'b0;
        we          = '0;
        dmem_addr   = word_q;
        dmem_din    = din_q;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                dmem_addr = word;
                dmem_din  = rot;
                if (req_valid) begin
                    off_d   = off;
                    word_d  = word;
                    f3_d    = req_funct3;
                    din_d   = rot;
                    cross_d = crossing;
                    if (err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_we) begin
                        we = we_lo;
                        if (crossing) begin
                            state_d = StStSplit;
                        end else begin
                            rsp_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = crossing ? StLdSplit : StLdWait;
                    end
                end
            end
            StLdWait: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ld_ext;
                state_d     = StIdle;
            end
`ifdef DMEM_LSU_MISALIGN_EN
            StLdSplit: begin
                hold_d    = dmem_dout;
                dmem_addr = word_q + 1'b1;
                state_d   = StLdWait;
            end
            StStSplit: begin
                dmem_addr   = word_q + 1'b1;
                we          = we_hi_q;
                rsp_valid_d = 1'b1;
                state_d     = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Gate enables during reset so an interrupted split never writes its second half.
    assign dmem_we = rsta ? we : 4'b0000;

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            state_q   <= StIdle;
            off_q     <= '0;
            word_q    <= '0;
            f3_q      <= '0;
            din_q     <= '0;
            hold_q    <= '0;
            cross_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            word_q    <= word_d;
            f3_q      <= f3_d;
            din_q     <= din_d;
            hold_q    <= hold_d;
            cross_q   <= cross_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with a byte-enabled 1-cycle-latency memory model.
// Expectations follow DMEM_LSU_MISALIGN_EN when it is defined for the build.
module tb_dmem_lsu;

    localparam int AW = 4;

    logic          clka = 1'b0;
    logic          rsta = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [3:0]    dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_din;
    logic [31:0]   dmem_dout = '0;

    dmem_lsu #(.ADDR_W(AW), .XLEN(32)) dut (
        .clka       (clka),
        .rsta       (rsta),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_din   (dmem_din),
        .dmem_dout  (dmem_dout)
    );

    always #5 clka = ~clka;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic prefill = 1'b1;

    always @(posedge clka) cyc <= cyc + 1;

    logic [31:0] mem [16];

    always @(posedge clka) begin
        if (prefill) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[1] <= 32'h8000_0000;
            mem[2] <= 32'h9ABC_0000;
        end else begin
            for (int i = 0; i < 4; i++)
                if (dmem_we[i]) mem[dmem_addr][8*i +: 8] <= dmem_din[8*i +: 8];
        end
        dmem_dout <= mem[dmem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];

    exp_t got;
    always @(negedge clka) begin
        if (rsta && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
            end else begin
                got = sb.pop_front();
                chk({got.name, "_rsp_cycle"}, 32'(cyc), 32'(got.cyc));
                chk({got.name, "_rsp_rdata"}, rsp_rdata, got.rd);
                chk({got.name, "_rsp_err"}, {31'b0, rsp_err}, {31'b0, got.err});
            end
        end
    end

    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [AW+1:0] addr, input logic [31:0] wd, input int lat,
                         input logic [31:0] exp_rd, input logic exp_err, input logic rsp_exp,
                         input logic [3:0] exp_we, input logic [31:0] exp_din);
        int   n = 0;
        exp_t e;
        @(negedge clka);
        while (!req_ready && n < 20) begin
            @(negedge clka);
            n++;
        end
        chk({name, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        if (rsp_exp) begin
            e.name = name;
            e.cyc  = cyc + lat;
            e.rd   = exp_rd;
            e.err  = exp_err;
            sb.push_back(e);
        end
        #2;
        chk({name, "_we"}, {28'b0, dmem_we}, {28'b0, exp_we});
        chk({name, "_addr"}, {28'b0, dmem_addr}, {28'b0, addr[AW+1:2]});
        if (exp_we != 4'b0000)
            chk({name, "_din"}, dmem_din & lanes(exp_we), exp_din & lanes(exp_we));
        @(posedge clka);
        #1;
        // Scramble the request so any late use of live inputs shows up.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = ~addr;
        req_wdata  = 32'h5A5A_5A5A;
    endtask

    task automatic chk_port(input string name, input logic [3:0] exp_we,
                            input logic [AW-1:0] exp_addr, input logic [31:0] exp_din);
        @(negedge clka);
        chk({name, "_we"}, {28'b0, dmem_we}, {28'b0, exp_we});
        if (exp_we != 4'b0000) begin
            chk({name, "_addr"}, {28'b0, dmem_addr}, {28'b0, exp_addr});
            chk({name, "_din"}, dmem_din & lanes(exp_we), exp_din & lanes(exp_we));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m3;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = '0;
        req_wdata  = 32'hFFFF_FFFF;
        repeat (3) @(posedge clka);
        @(negedge clka);
        chk("rst_dmem_we", {28'b0, dmem_we}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
        prefill   = 1'b0;
        rsta      = 1'b1;

        issue("sb06", 1, 3'b000, 6'h06, 32'h0000_00A5, 1, 32'h0, 0, 1, 4'b0100, 32'h00A5_0000);
        issue("lb06", 0, 3'b000, 6'h06, 32'h0, 2, 32'hFFFF_FFA5, 0, 1, 4'b0000, 32'h0);
        issue("lbu06", 0, 3'b100, 6'h06, 32'h0, 2, 32'h0000_00A5, 0, 1, 4'b0000, 32'h0);
        issue("lh06", 0, 3'b001, 6'h06, 32'h0, 2, 32'hFFFF_80A5, 0, 1, 4'b0000, 32'h0);
        issue("lw04", 0, 3'b010, 6'h04, 32'h0, 2, 32'h80A5_0000, 0, 1, 4'b0000, 32'h0);
        issue("sh08", 1, 3'b001, 6'h08, 32'h0000_1234, 1, 32'h0, 0, 1, 4'b0011, 32'h0000_1234);
        issue("lhu0a", 0, 3'b101, 6'h0A, 32'h0, 2, 32'h0000_9ABC, 0, 1, 4'b0000, 32'h0);
        issue("lh0a", 0, 3'b001, 6'h0A, 32'h0, 2, 32'hFFFF_9ABC, 0, 1, 4'b0000, 32'h0);
        issue("lhu08", 0, 3'b101, 6'h08, 32'h0, 2, 32'h0000_1234, 0, 1, 4'b0000, 32'h0);
        issue("sw0c", 1, 3'b010, 6'h0C, 32'hDEAD_BEEF, 1, 32'h0, 0, 1, 4'b1111, 32'hDEAD_BEEF);
        issue("lw0c", 0, 3'b010, 6'h0C, 32'h0, 2, 32'hDEAD_BEEF, 0, 1, 4'b0000, 32'h0);
        issue("sbu_err", 1, 3'b100, 6'h00, 32'hFFFF_FFFF, 1, 32'h0, 1, 1, 4'b0000, 32'h0);
        chk_port("sbu_err_t1", 4'b0000, '0, 32'h0);
        issue("ld011_err", 0, 3'b011, 6'h00, 32'h0, 1, 32'h0, 1, 1, 4'b0000, 32'h0);
        issue("st110_err", 1, 3'b110, 6'h04, 32'hFFFF_FFFF, 1, 32'h0, 1, 1, 4'b0000, 32'h0);

`ifndef DMEM_LSU_MISALIGN_EN
        issue("lw05_err", 0, 3'b010, 6'h05, 32'h0, 1, 32'h0, 1, 1, 4'b0000, 32'h0);
        chk_port("lw05_err_t1", 4'b0000, '0, 32'h0);
        issue("lh07_err", 0, 3'b001, 6'h07, 32'h0, 1, 32'h0, 1, 1, 4'b0000, 32'h0);
        issue("sh01_err", 1, 3'b001, 6'h01, 32'hFFFF_FFFF, 1, 32'h0, 1, 1, 4'b0000, 32'h0);
        issue("sw02_err", 1, 3'b010, 6'h02, 32'hFFFF_FFFF, 1, 32'h0, 1, 1, 4'b0000, 32'h0);
        chk_port("sw02_err_t1", 4'b0000, '0, 32'h0);
        issue("lw08", 0, 3'b010, 6'h08, 32'h0, 2, 32'h9ABC_1234, 0, 1, 4'b0000, 32'h0);
`else
        issue("lh05", 0, 3'b001, 6'h05, 32'h0, 2, 32'hFFFF_A500, 0, 1, 4'b0000, 32'h0);
        issue("sw07", 1, 3'b010, 6'h07, 32'h1122_3344, 2, 32'h0, 0, 1, 4'b1000, 32'h4400_0000);
        chk_port("sw07_t1", 4'b0111, 4'd2, 32'h0011_2233);
        issue("lw07", 0, 3'b010, 6'h07, 32'h0, 3, 32'h1122_3344, 0, 1, 4'b0000, 32'h0);
        issue("sh3f", 1, 3'b001, 6'h3F, 32'h0000_BEEF, 2, 32'h0, 0, 1, 4'b1000, 32'hEF00_0000);
        chk_port("sh3f_t1", 4'b0001, 4'd0, 32'h0000_00BE);
        issue("lhu3f", 0, 3'b101, 6'h3F, 32'h0, 3, 32'h0000_BEEF, 0, 1, 4'b0000, 32'h0);
        issue("lh3f", 0, 3'b001, 6'h3F, 32'h0, 3, 32'hFFFF_BEEF, 0, 1, 4'b0000, 32'h0);

        // Reset in the second cycle of a split store must drop the upper-word write.
        m3 = mem[3];
        issue("sw0b", 1, 3'b010, 6'h0B, 32'hCAFE_F00D, 2, 32'h0, 0, 0, 4'b1000, 32'h0D00_0000);
        rsta = 1'b0;
        #2;
        chk("sw0b_we_in_rst", {28'b0, dmem_we}, 32'd0);
        #1;
        rsta = 1'b1;
        @(negedge clka);
        chk("sw0b_ready_after_rst", {31'b0, req_ready}, 32'd1);
        chk("sw0b_we_after_rst", {28'b0, dmem_we}, 32'd0);
        repeat (3) @(negedge clka);
        chk("sw0b_word3_kept", mem[3], m3);
        issue("lw0c_post", 0, 3'b010, 6'h0C, 32'h0, 2, 32'hDEAD_BEEF, 0, 1, 4'b0000, 32'h0);
`endif

        repeat (6) @(negedge clka);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
